// File: rtl/ahbl_gpio_port_if.sv
// ahbl_gpio_port_if: AHB-Lite bus signals between the initiator and the GPIO subordinate
interface ahbl_gpio_port_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  modport master (output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, input HRDATA, HREADYOUT, HRESP);
  modport slave (input HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA, output HRDATA, HREADYOUT, HRESP);
endinterface

// File: rtl/ahbl_gpio_port.sv
// ahbl_gpio_port: AHB-Lite GPIO subordinate with data/OE registers, input sync and sticky edge IRQ
module ahbl_gpio_port #(
  parameter int WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahbl_gpio_port_if.slave  bus,
  input  logic [WIDTH-1:0] GPIO_IN,
  output logic [WIDTH-1:0] GPIO_OUT,
  output logic [WIDTH-1:0] GPIO_OE,
  output logic             IRQ
);
  logic accept;
  logic [3:0] lanes;
  logic dp_valid, dp_write;
  logic [2:0] dp_addr;
  logic [3:0] dp_lanes;
  logic [31:0] lm32, wm32, rd;
  logic [WIDTH-1:0] lm, wm, dout, oe, ie, edge_sel, is, din, prev, ev;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic wr;
  logic unused_bits;
  assign unused_bits = ^{bus.HADDR[31:5], bus.HTRANS[0], bus.HSIZE[2]};
  assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  always_comb lanes = bus.HSIZE[1] ? 4'hF : bus.HSIZE[0] ? (bus.HADDR[1] ? 4'hC : 4'h3) : 4'(1 << bus.HADDR[1:0]);
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_lanes <= '0;
    end else if (bus.HREADY) begin
      dp_valid <= accept;
      if (accept) begin
        dp_write <= bus.HWRITE;
        dp_addr  <= bus.HADDR[4:2];
        dp_lanes <= lanes;
      end
    end
  assign lm32 = {{8{dp_lanes[3]}}, {8{dp_lanes[2]}}, {8{dp_lanes[1]}}, {8{dp_lanes[0]}}};
  assign wm32 = bus.HWDATA & lm32;
  assign lm = lm32[WIDTH-1:0];
  assign wm = wm32[WIDTH-1:0];
  assign wr = dp_valid & dp_write & bus.HREADY;
  assign din = sync[SYNC_STAGES-1];
  assign ev = (din & ~prev & ~edge_sel) | (~din & prev & edge_sel);
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      sync     <= '0;
      prev     <= '0;
      dout     <= '0;
      oe       <= '0;
      ie       <= '0;
      edge_sel <= '0;
      is       <= '0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], GPIO_IN};
      prev     <= din;
      dout     <= (wr && dp_addr == 3'd1) ? (dout & ~lm) | wm :
                  (wr && dp_addr == 3'd6) ? dout | wm :
                  (wr && dp_addr == 3'd7) ? dout & ~wm : dout;
      oe       <= (wr && dp_addr == 3'd2) ? (oe & ~lm) | wm : oe;
      ie       <= (wr && dp_addr == 3'd3) ? (ie & ~lm) | wm : ie;
      edge_sel <= (wr && dp_addr == 3'd4) ? (edge_sel & ~lm) | wm : edge_sel;
      // a fresh edge is ORed in after the W1C so the set wins on a collision
      is       <= ((wr && dp_addr == 3'd5) ? is & ~wm : is) | ev;
    end
  always_comb
    rd = dp_addr == 3'd0 ? 32'(din) :
         dp_addr == 3'd1 ? 32'(dout) :
         dp_addr == 3'd2 ? 32'(oe) :
         dp_addr == 3'd3 ? 32'(ie) :
         dp_addr == 3'd4 ? 32'(edge_sel) :
         dp_addr == 3'd5 ? 32'(is) : 32'd0;
  assign bus.HRDATA    = (dp_valid & ~dp_write) ? rd : 32'd0;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
  assign GPIO_OUT      = dout;
  assign GPIO_OE       = oe;
  assign IRQ           = |(is & ie);
endmodule

// File: tb/tb_ahbl_gpio_port.sv
// tb_ahbl_gpio_port: directed AHB-Lite transfers against hand-computed register and pin values
module tb_ahbl_gpio_port;
  logic HCLK, HRESETn;
  logic [31:0] GPIO_IN, GPIO_OUT, GPIO_OE;
  logic IRQ;
  int n_cmp = 0, n_err = 0;
  logic [31:0] v;
  ahbl_gpio_port_if bus ();
  ahbl_gpio_port #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus),
    .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT), .GPIO_OE(GPIO_OE), .IRQ(IRQ)
  );
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask
  task automatic ap(input logic w, input logic [31:0] a, input logic [2:0] s);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = w; bus.HADDR = a; bus.HSIZE = s;
  endtask
  task automatic idle;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    ap(1'b1, a, s);
    tick;
    idle;
    bus.HWDATA = d;
    tick;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    ap(1'b0, a, 3'd2);
    tick;
    idle;
    d = bus.HRDATA;
  endtask
  initial begin
    HRESETn = 1'b0; GPIO_IN = '0; bus.HREADY = 1'b1; bus.HWDATA = '0;
    bus.HADDR = '0; bus.HSIZE = 3'd2; idle;
    #23 HRESETn = 1'b1;
    tick;
    chk("rst_out", GPIO_OUT, 0);
    chk("rst_oe", GPIO_OE, 0);
    chk("rst_irq", {31'd0, IRQ}, 0);
    chk("rst_hrdata", bus.HRDATA, 0);
    chk("rst_hready", {31'd0, bus.HREADYOUT}, 1);
    chk("rst_hresp", {31'd0, bus.HRESP}, 0);
    wr(32'h04, 3'd2, 32'hA5A5_0F0F);
    chk("t1_out", GPIO_OUT, 32'hA5A5_0F0F);
    wr(32'h08, 3'd2, 32'hFFFF_0000);
    chk("t1_oe", GPIO_OE, 32'hFFFF_0000);
    rd(32'h04, v); chk("t1_rd_dout", v, 32'hA5A5_0F0F);
    rd(32'h08, v); chk("t1_rd_oe", v, 32'hFFFF_0000);
    wr(32'h04, 3'd2, 32'h0);
    wr(32'h05, 3'd0, 32'h0000_3C00);
    chk("t2_byte", GPIO_OUT, 32'h0000_3C00);
    wr(32'h06, 3'd1, 32'hFFFF_FFFF);
    chk("t2_half", GPIO_OUT, 32'hFFFF_3C00);
    wr(32'h04, 3'd2, 32'h0000_3C00);
    wr(32'h18, 3'd2, 32'h1);
    chk("t2_set", GPIO_OUT, 32'h0000_3C01);
    wr(32'h1C, 3'd2, 32'h400);
    chk("t2_clr", GPIO_OUT, 32'h0000_3801);
    rd(32'h18, v); chk("t2_rd_set", v, 0);
    wr(32'h10, 3'd2, 32'h0);
    wr(32'h0C, 3'd2, 32'h8);
    ap(1'b0, 32'h00, 3'd2);
    GPIO_IN = 32'h8;
    tick;
    chk("t3_din_1cyc", bus.HRDATA, 0);
    ap(1'b0, 32'h00, 3'd2);
    tick;
    idle;
    chk("t3_din_2cyc", bus.HRDATA, 32'h8);
    chk("t3_irq_pre", {31'd0, IRQ}, 0);
    tick;
    chk("t3_irq", {31'd0, IRQ}, 1);
    rd(32'h14, v); chk("t3_is", v, 32'h8);
    wr(32'h14, 3'd2, 32'h8);
    chk("t3_irq_clr", {31'd0, IRQ}, 0);
    rd(32'h14, v); chk("t3_is_clr", v, 0);
    wr(32'h10, 3'd2, 32'h8);
    GPIO_IN = 32'h0;
    tick;
    ap(1'b1, 32'h14, 3'd2);
    tick;
    idle;
    bus.HWDATA = 32'h8;
    tick;
    chk("t4_irq", {31'd0, IRQ}, 1);
    rd(32'h14, v); chk("t4_is", v, 32'h8);
    tick;
    chk("t4_irq_hold", {31'd0, IRQ}, 1);
    ap(1'b1, 32'h08, 3'd2);
    tick;
    bus.HWDATA = 32'hFF;
    ap(1'b0, 32'h08, 3'd2);
    tick;
    idle;
    chk("t5_b2b", bus.HRDATA, 32'hFF);
    rd(32'h20, v); chk("t5_hole", v, 0);
    chk("t5_hresp", {31'd0, bus.HRESP}, 0);
    tick;
    chk("t5_idle_rd", bus.HRDATA, 0);
    wr(32'h04, 3'd2, 32'h0);
    ap(1'b1, 32'h04, 3'd2);
    tick;
    idle;
    bus.HWDATA = 32'h1234;
    #2 HRESETn = 1'b0;
    @(posedge HCLK);
    #1;
    chk("t6_out", GPIO_OUT, 0);
    chk("t6_oe", GPIO_OE, 0);
    chk("t6_irq", {31'd0, IRQ}, 0);
    chk("t6_hrdata", bus.HRDATA, 0);
    chk("t6_hready", {31'd0, bus.HREADYOUT}, 1);
    #3 HRESETn = 1'b1;
    tick;
    chk("t6_out_after", GPIO_OUT, 0);
    rd(32'h04, v); chk("t6_rd_dout", v, 0);
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
